hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the write-enable of the PC and IF/ID register, and the flush of IF/ID.
- Drives the bubble (synchronous clear) input of the ID/EX pipeline register.
- Resolves load-use hazards, taken-branch squashes and multi-cycle mult/div occupancy via a small FSM.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MULDIV_CYCLES, 32, total EX occupancy of a mult/div op in cycles; legal range 1..255.
CNT_W, 16, width of stall_cycles counter.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_muldiv  in  1  ID instruction is mult/multu/div/divu
ex_memread  in  1  instruction in EX is a load (memctrl read bit of ID/EX output)
ex_rt  in  5  destination rt of instruction in EX
branch_taken  in  1  EX resolved a taken branch/jump this cycle
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID clear (loads zeros, i.e. nop)
idex_bubble  out  1  drive ID/EX reset input: zero controls into EX
muldiv_busy  out  1  registered: FSM in BUSY
stall_cycles  out  CNT_W  count of cycles with pc_write=0, saturating

Behaviour:
- Clock and reset:
  - Single clock.
  - reset is synchronous and active-high.
  - While reset=1, outputs are forced: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, muldiv_busy=0, stall_cycles=0.
  - On the next edge with reset=1: state=RUN, busy counter=0.
  - Reset mid-BUSY aborts the op; the cycle after reset deasserts is RUN.
  - Reset cycles are not counted.
- load_use hazard (combinational):
  - load_use = ex_memread && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- FSM states: RUN, BUSY. Outputs are Mealy and combinational, except muldiv_busy and stall_cycles.
- RUN priority, highest first:
  1. branch_taken:
     - Outputs pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
     - load_use and id_muldiv are ignored (ID instruction squashed).
     - Stay in RUN.
  2. load_use:
     - Outputs pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
     - Stay in RUN. Exactly one bubble per load-use pair, since next cycle EX holds the bubble.
  3. id_muldiv:
     - Outputs pc_write=1, ifid_write=1, no flush, no bubble; the op issues to EX this cycle.
     - If MULDIV_CYCLES>1: next state BUSY, counter<=MULDIV_CYCLES-1. Otherwise stay in RUN.
  4. Otherwise:
     - Outputs pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- BUSY:
  - Default outputs: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  - Counter decrements each cycle. When counter==1 on an edge, the next state is RUN.
  - Net effect: exactly MULDIV_CYCLES-1 stall cycles follow the issue cycle.
  - load_use and id_muldiv are ignored in BUSY; hazards are re-evaluated in RUN.
  - branch_taken in BUSY:
    - Outputs the RUN-branch pattern (pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1).
    - Counter<=0, next state RUN (abort).
- muldiv_busy:
  - Registered, equals (state==BUSY). Asserts the cycle after issue and deasserts the cycle RUN resumes.
- stall_cycles:
  - On each edge with reset=0 and pc_write=0, increments by 1.
  - Holds at 2^CNT_W-1; no wrap.
- Simultaneous events:
  - branch_taken dominates everything.
  - load_use dominates id_muldiv: the mult/div waits one cycle, then issues.

Test Plan:
1. Load-use: ex_memread=1, ex_rt=8, id_rs=8 for one cycle, then ex_memread=0 -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles=1.
2. $zero and rt-unused filtering:
   - ex_memread=1, ex_rt=0, id_rs=0 -> no stall.
   - ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
   - Same with id_uses_rt=1 -> one-cycle stall.
3. Mult/div with MULDIV_CYCLES=4: id_muldiv=1 pulse -> issue cycle pc_write=1; then 3 cycles pc_write=0, idex_bubble=1, muldiv_busy=1; then RUN; stall_cycles=3.
4. Branch priority and abort:
   - branch_taken=1 with load_use=1 and id_muldiv=1 in RUN -> ifid_flush=1, idex_bubble=1, pc_write=1; no BUSY entry.
   - branch_taken=1 on 2nd BUSY cycle -> flush pattern, muldiv_busy=0 next cycle.
5. Reset mid-BUSY: reset=1 during BUSY, then released -> reset-cycle outputs (pc_write=0, ifid_flush=1, idex_bubble=1); first cycle after release in RUN with pc_write=1, muldiv_busy=0, stall_cycles=0.
6. Counter saturation, CNT_W=4: 20 BUSY stall cycles (MULDIV_CYCLES=21) -> stall_cycles stops at 15.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from ID/EX and pipeline control outputs of the hazard sequencer.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_muldiv;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             branch_taken;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             muldiv_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_muldiv, ex_memread, ex_rt, branch_taken,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_muldiv, ex_memread, ex_rt, branch_taken,
        output pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for load-use, taken-branch and multi-cycle mult/div hazards.
module hazard_ctrl #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 16
) (
    input logic    clock,
    input logic    reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, BUSY} state_t;

    localparam logic [7:0] ISSUE_LEFT = 8'(MULDIV_CYCLES - 1);

    state_t           state, state_d;
    logic [7:0]       left, left_d;
    logic [CNT_W-1:0] stalls;
    logic             load_use;
    logic             pc_we, ifid_we, flush, bubble;

    always_comb load_use = hz.ex_memread && hz.ex_rt != 5'd0 &&
                           (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));

    // Priority: reset, branch squash, mult/div occupancy, load-use, mult/div issue.
    always_comb begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        flush   = 1'b0;
        bubble  = 1'b0;
        state_d = state;
        left_d  = left;
        if (reset) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = RUN;
            left_d  = 8'd0;
        end else if (hz.branch_taken) begin
            flush   = 1'b1;
            bubble  = 1'b1;
            state_d = RUN;
            left_d  = 8'd0;
        end else if (state == BUSY) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
            left_d  = left - 8'd1;
            state_d = left <= 8'd1 ? RUN : BUSY;
        end else if (load_use) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
        end else if (hz.id_muldiv && MULDIV_CYCLES > 1) begin
            state_d = BUSY;
            left_d  = ISSUE_LEFT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= RUN;
            left   <= 8'd0;
            stalls <= '0;
        end else begin
            state  <= state_d;
            left   <= left_d;
            stalls <= (!pc_we && !(&stalls)) ? stalls + 1'b1 : stalls;
        end
    end

    assign hz.pc_write     = pc_we;
    assign hz.ifid_write   = ifid_we;
    assign hz.ifid_flush   = flush;
    assign hz.idex_bubble  = bubble;
    assign hz.muldiv_busy  = !reset && state == BUSY;
    assign hz.stall_cycles = reset ? '0 : stalls;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: random hazard stimulus on three configurations checked against a cycle-indexed model.
module tb_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    hazard_ctrl_if #(.CNT_W(16)) ia ();
    hazard_ctrl_if #(.CNT_W(4))  ib ();
    hazard_ctrl_if #(.CNT_W(16)) ic ();

    hazard_ctrl #(.MULDIV_CYCLES(4),  .CNT_W(16)) dut_a (.clock(clock), .reset(reset), .hz(ia));
    hazard_ctrl #(.MULDIV_CYCLES(21), .CNT_W(4))  dut_b (.clock(clock), .reset(reset), .hz(ib));
    hazard_ctrl #(.MULDIV_CYCLES(1),  .CNT_W(16)) dut_c (.clock(clock), .reset(reset), .hz(ic));

    logic [4:0]  obs [3];
    logic [15:0] obs_cnt [3];
    assign obs[0] = {ia.pc_write, ia.ifid_write, ia.ifid_flush, ia.idex_bubble, ia.muldiv_busy};
    assign obs[1] = {ib.pc_write, ib.ifid_write, ib.ifid_flush, ib.idex_bubble, ib.muldiv_busy};
    assign obs[2] = {ic.pc_write, ic.ifid_write, ic.ifid_flush, ic.idex_bubble, ic.muldiv_busy};
    assign obs_cnt[0] = ia.stall_cycles;
    assign obs_cnt[1] = {12'd0, ib.stall_cycles};
    assign obs_cnt[2] = ic.stall_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic md,
                         input logic mr, input logic [4:0] ert, input logic br);
        ia.id_rs = rs; ia.id_rt = rt; ia.id_uses_rt = ur; ia.id_muldiv = md;
        ia.ex_memread = mr; ia.ex_rt = ert; ia.branch_taken = br;
        ib.id_rs = rs; ib.id_rt = rt; ib.id_uses_rt = ur; ib.id_muldiv = md;
        ib.ex_memread = mr; ib.ex_rt = ert; ib.branch_taken = br;
        ic.id_rs = rs; ic.id_rt = rt; ic.id_uses_rt = ur; ic.id_muldiv = md;
        ic.ex_memread = mr; ic.ex_rt = ert; ic.branch_taken = br;
    endtask

    function automatic logic [4:0] pick_reg();
        int s = $urandom_range(0, 3);
        return s == 0 ? 5'd0 : s == 1 ? 5'd8 : s == 2 ? 5'd9 : 5'($urandom_range(0, 31));
    endfunction

    // Model: a mult/div issued at cycle t stalls cycles t+1 .. t+mc-1, so occupancy is
    // "current cycle <= stall_end"; the counter is a saturating integer.
    int mc [3] = '{4, 21, 1};
    int cw [3] = '{16, 4, 16};
    int stall_end [3] = '{-1, -1, -1};
    int cnt [3] = '{0, 0, 0};

    initial begin
        logic [4:0] rs, rt, ert, exp;
        logic ur, md, mr, br, lu, busy;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock);
            #1;
            reset = (c < 2) || ($urandom_range(0, 199) == 0);
            rs = pick_reg(); rt = pick_reg(); ert = pick_reg();
            ur = 1'($urandom_range(0, 1));
            md = $urandom_range(0, 5) == 0;
            mr = $urandom_range(0, 2) == 0;
            br = $urandom_range(0, 15) == 0;
            drive(rs, rt, ur, md, mr, ert, br);
            #3;
            lu = mr && ert != 0 && (ert == rs || (ur && ert == rt));
            for (int k = 0; k < 3; k++) begin
                busy = c <= stall_end[k];
                if (reset)    exp = 5'b00110;
                else if (br)  exp = {4'b1111, busy};
                else if (busy) exp = 5'b00011;
                else if (lu)  exp = 5'b00010;
                else          exp = 5'b11000;
                check($sformatf("ctrl%0d", k), 32'(obs[k]), 32'(exp));
                check($sformatf("stalls%0d", k), 32'(obs_cnt[k]), reset ? 32'd0 : 32'(cnt[k]));
                if (reset) begin
                    cnt[k] = 0;
                    stall_end[k] = c;
                end else begin
                    if (!exp[4] && cnt[k] < (1 << cw[k]) - 1) cnt[k]++;
                    if (br) stall_end[k] = c;
                    else if (!busy && !lu && md) stall_end[k] = c + mc[k] - 1;
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
